hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 32, max MDWAIT cycles before abort (range 2..63).
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- nrst  in  1  asynchronous, active-low reset.
- IF_ID_rs  in  5  rs of instruction in ID.
- IF_ID_rt  in  5  rt of instruction in ID.
- ID_uses_rt  in  1  ID instruction reads rt.
- ID_EX_rt  in  5  destination of instruction in EX.
- ID_EX_Mem_Read  in  1  EX instruction is a load.
- branch_taken  in  1  EX resolved a taken branch/jump.
- md_start  in  1  EX holds a multi-cycle mul/div.
- md_done  in  1  mul/div unit result valid.
- PC_Write  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- ID_EX_Bubble  out  1  load NOP into ID/EX.
- ID_EX_Hold  out  1  hold ID/EX contents.
- IF_ID_Flush  out  1  clear IF/ID.
- ID_EX_Flush  out  1  clear ID/EX.
- md_error  out  1  one-cycle timeout pulse, registered.
- state  out  2  current FSM state.
- stall_cycles  out  16  stall statistics counter.

Function
REQ-003 SHALL implement FSM RUN=2'b00, LDSTALL=2'b01, MDWAIT=2'b10, FLUSH=2'b11; state output equals register.
REQ-004 SHALL define load_use = ID_EX_Mem_Read && ID_EX_rt!=0 && (ID_EX_rt==IF_ID_rs || (ID_uses_rt && ID_EX_rt==IF_ID_rt)).
REQ-005 Default outputs SHALL be PC_Write=1, IF_ID_Write=1, all others 0.
REQ-006 In RUN, priority SHALL be branch_taken > md_start > load_use; outputs combinational from state and inputs.
REQ-007 RUN+branch_taken SHALL drive IF_ID_Flush=1, ID_EX_Flush=1 same cycle, PC_Write=1; next state FLUSH.
REQ-008 RUN+md_start (no branch) SHALL drive defaults that cycle; next state MDWAIT, wait counter cleared.
REQ-009 RUN+load_use (neither above) SHALL drive PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 same cycle; next state LDSTALL.
REQ-010 LDSTALL SHALL drive defaults with load_use ignored; branch_taken acts as REQ-007; else next RUN; exactly one bubble per load.
REQ-011 FLUSH SHALL drive defaults, ignore load_use and md_start, next RUN unconditionally.
REQ-012 MDWAIT without md_done SHALL drive PC_Write=0, IF_ID_Write=0, ID_EX_Hold=1, increment 6-bit wait counter; branch_taken ignored.
REQ-013 MDWAIT with md_done SHALL drive defaults that cycle, next RUN; md_done outside MDWAIT ignored.
REQ-014 MDWAIT when counter==MD_TIMEOUT-1 and no md_done SHALL return to RUN next cycle and pulse md_error for exactly that next cycle.
REQ-015 md_done and timeout same cycle SHALL resolve as done; no md_error.
REQ-016 ID_EX_Bubble and ID_EX_Hold SHALL never be asserted together.

Reset
REQ-017 nrst low SHALL asynchronously force state=RUN, wait counter=0, md_error=0, stall_cycles=0.
REQ-018 Reset mid-MDWAIT or mid-LDSTALL SHALL abandon the sequence; first cycle after release behaves as RUN.

Configuration
REQ-019 With HAZARD_STATS_EN defined, stall_cycles SHALL increment each cycle PC_Write==0, saturating at 16'hFFFF.
REQ-020 Without HAZARD_STATS_EN, stall_cycles SHALL be constant 0 with no counter flops.

Verification
REQ-021 Load-use: ID_EX_Mem_Read=1, ID_EX_rt=5, IF_ID_rs=5 in RUN -> one cycle PC_Write=0, ID_EX_Bubble=1, then LDSTALL, then RUN with defaults.
REQ-022 Zero register: ID_EX_rt=0, IF_ID_rs=0, load -> no stall, state stays RUN.
REQ-023 Mul/div: md_start pulse, md_done 4 cycles later -> 4 cycles PC_Write=0, ID_EX_Hold=1, state=MDWAIT; stall_cycles=4 with HAZARD_STATS_EN.
REQ-024 Timeout: MD_TIMEOUT=4, md_start, md_done never -> 4 hold cycles, then state=RUN and md_error=1 for one cycle.
REQ-025 Priority: branch_taken, md_start, load_use all high in RUN -> flush both, PC_Write=1, next state FLUSH, no MDWAIT entry.
REQ-026 Reset in MDWAIT: nrst low 2 cycles at wait count 3 -> state=RUN immediately, stall_cycles=0, no md_error after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | hazard_ctrl : pipeline hazard controller (load-use stall, branch flush,   |
// |               multi-cycle mul/div hold with timeout).                     |
// | Optional: define HAZARD_STATS_EN to enable the stall_cycles counter.      |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        ID_uses_rt,
  input  logic [4:0]  ID_EX_rt,
  input  logic        ID_EX_Mem_Read,
  input  logic        branch_taken,
  input  logic        md_start,
  input  logic        md_done,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        ID_EX_Bubble,
  output logic        ID_EX_Hold,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        md_error,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    MDWAIT  = 2'b10,
    FLUSH   = 2'b11
  } state_t;

  localparam logic [5:0] C_TIMEOUT_LAST = 6'(MD_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [5:0] wait_q, wait_d;
  logic       md_error_q, md_error_d;
  logic       load_use;

  assign load_use = ID_EX_Mem_Read && (ID_EX_rt != 5'd0) &&
                    ((ID_EX_rt == IF_ID_rs) || (ID_uses_rt && (ID_EX_rt == IF_ID_rt)));

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    md_error_d   = 1'b0;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    ID_EX_Hold   = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
          state_d     = FLUSH;
        end else if (md_start) begin
          wait_d  = 6'd0;
          state_d = MDWAIT;
        end else if (load_use) begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          state_d      = LDSTALL;
        end
      end
      // The bubble was already inserted on entry, so load_use is not re-evaluated here.
      LDSTALL: begin
        if (branch_taken) begin
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
          state_d     = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      MDWAIT: begin
        if (md_done) begin
          state_d = RUN;
        end else begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Hold  = 1'b1;
          wait_d      = wait_q + 6'd1;
          if (wait_q == C_TIMEOUT_LAST) begin
            state_d    = RUN;
            md_error_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= RUN;
      wait_q     <= 6'd0;
      md_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      md_error_q <= md_error_d;
    end
  end

  assign state    = state_q;
  assign md_error = md_error_q;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_q <= 16'd0;
    end else if (!PC_Write && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule
`default_nettype wire
